fetch_stage: RTL and testbench

//  IF stage + IF/ID pipeline register of the 5-stage MIPS core. Holds PC, fetches

---
 rtl/fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage and IF/ID pipeline register with req/ack instruction fetch
//
// Purpose: holds the PC, fetches instructions over a variable-latency req/ack
// memory handshake, and delivers instrD/pcplus4D/validD to decode. It also
// handles hazard-unit stalls and redirects from branches and jumps resolved in D.
// There is no delay slot, so a redirect squashes any instruction fetched in the
// same cycle.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   stallF, stallD            hazard unit: no new fetch / hold IF/ID
//   pcsrcD, pcbranchD         branch taken in D and its target
//   jumpD, pcjumpD            jump in D and its target
//   imem_req, imem_addr       fetch request and registered fetch address
//   imem_ack, imem_rdata      response strobe and instruction word
//   instrD, pcplus4D, validD  IF/ID register contents

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  input  logic        jumpD,
  input  logic [31:0] pcjumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc_f;
  logic [31:0] buf_instr;
  logic [31:0] buf_pcplus4;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        req_int;
  logic        accept;

  // A redirect is only acted on when decode is actually advancing.
  // When both a branch and a jump are signalled, the branch target wins.
  assign redirect = !stallD && (pcsrcD || jumpD);
  assign target   = pcsrcD ? pcbranchD : pcjumpD;
  assign pc_plus4 = pc_f + 32'd4;

  always_comb begin
    req_int = 1'b0;
    case (state)
      S_FETCH: req_int = !stallF;
      S_WAIT:  req_int = 1'b1;
      S_DROP:  req_int = 1'b1;
      default: req_int = 1'b0;
    endcase
  end

  // Force the request low while reset is held.
  // Any ack that arrives during or just after reset therefore has nothing to pair with.
  assign imem_req = rst && req_int;

  // A response becomes a real instruction only in FETCH or WAIT.
  // In DROP the response belongs to a squashed fetch.
  assign accept = req_int && imem_ack && (state == S_FETCH || state == S_WAIT);

  // In FETCH and WAIT, imem_addr always equals pc_f.
  // Only DROP lets them diverge: pc_f already points at the redirect target,
  // while the bus still carries the abandoned address until its ack arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_FETCH;
      pc_f        <= RESET_PC;
      imem_addr   <= RESET_PC;
      buf_instr   <= 32'd0;
      buf_pcplus4 <= 32'd0;
      instrD      <= 32'd0;
      pcplus4D    <= 32'd0;
      validD      <= 1'b0;
    end else begin
      case (state)
        S_FETCH, S_WAIT: begin
          if (req_int && imem_ack) begin
            if (redirect) begin
              pc_f      <= target;
              imem_addr <= target;
              state     <= S_FETCH;
            end else begin
              pc_f      <= pc_plus4;
              imem_addr <= pc_plus4;
              if (stallD) begin
                buf_instr   <= imem_rdata;
                buf_pcplus4 <= pc_plus4;
                state       <= S_HOLD;
              end else begin
                state <= S_FETCH;
              end
            end
          end else if (req_int) begin
            // The request is still outstanding.
            // The address must stay put until the ack arrives.
            if (redirect) begin
              pc_f  <= target;
              state <= S_DROP;
            end else begin
              state <= S_WAIT;
            end
          end else if (redirect) begin
            pc_f      <= target;
            imem_addr <= target;
          end
        end
        S_HOLD: begin
          if (!stallD) begin
            state <= S_FETCH;
            if (redirect) begin
              pc_f      <= target;
              imem_addr <= target;
            end
          end
        end
        S_DROP: begin
          if (redirect) begin
            pc_f <= target;
          end
          if (imem_ack) begin
            state     <= S_FETCH;
            imem_addr <= redirect ? target : pc_f;
          end
        end
        default: state <= S_FETCH;
      endcase

      // IF/ID register.
      // A bubble clears instrD and validD but leaves pcplus4D untouched.
      if (!stallD) begin
        if (redirect) begin
          instrD <= 32'd0;
          validD <= 1'b0;
        end else if (state == S_HOLD) begin
          instrD   <= buf_instr;
          pcplus4D <= buf_pcplus4;
          validD   <= 1'b1;
        end else if (accept) begin
          instrD   <= imem_rdata;
          pcplus4D <= pc_plus4;
          validD   <= 1'b1;
        end else begin
          instrD <= 32'd0;
          validD <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, stallD, pcsrcD, jumpD;
  logic [31:0] pcbranchD, pcjumpD;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instrD, pcplus4D;
  logic        validD;

  logic auto_ack;
  logic man_ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory model: returns addr|0xA000.
  // Zero-wait mode acks in the same cycle as the request.
  // Otherwise the ack is driven directly by the stimulus.
  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = imem_addr | 32'h0000_A000;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .stallF(stallF), .stallD(stallD),
    .pcsrcD(pcsrcD), .pcbranchD(pcbranchD),
    .jumpD(jumpD), .pcjumpD(pcjumpD),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instrD(instrD), .pcplus4D(pcplus4D), .validD(validD)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr);
    #1;
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic chk_d(input string tag, input logic [31:0] ins, input logic [31:0] p4, input logic v);
    chk({tag, ".instrD"}, instrD, ins);
    chk({tag, ".pcplus4D"}, pcplus4D, p4);
    chk({tag, ".validD"}, {31'd0, validD}, {31'd0, v});
  endtask

  initial begin
    rst = 1'b0; stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0;
    pcbranchD = 32'd0; pcjumpD = 32'd0; auto_ack = 1'b1; man_ack = 1'b0;
    #2;
    chk_bus("rst", 1'b0, 32'h0);
    chk_d("rst", 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b1;

    // 1: zero-wait memory streams one instruction per cycle.
    chk_bus("t1c0", 1'b1, 32'h0);
    tick();
    chk_d("t1e0", 32'h0000_A000, 32'h4, 1'b1);
    chk_bus("t1c1", 1'b1, 32'h4);
    tick();
    chk_d("t1e1", 32'h0000_A004, 32'h8, 1'b1);

    // 2: the ack for 0x8 arrives in the third request cycle.
    auto_ack = 1'b0; man_ack = 1'b0;
    chk_bus("t2c2", 1'b1, 32'h8);
    tick();
    chk_d("t2e2", 32'h0, 32'h8, 1'b0);
    chk_bus("t2c3", 1'b1, 32'h8);
    tick();
    chk_d("t2e3", 32'h0, 32'h8, 1'b0);
    man_ack = 1'b1;
    chk_bus("t2c4", 1'b1, 32'h8);
    tick();
    chk_d("t2e4", 32'h0000_A008, 32'hC, 1'b1);

    // 3: stallD on the ack for 0xC parks the word in HOLD.
    // The IF/ID register keeps 0xA008 until the stall is released.
    man_ack = 1'b0; auto_ack = 1'b1; stallD = 1'b1;
    chk_bus("t3c5", 1'b1, 32'hC);
    tick();
    chk_d("t3e5", 32'h0000_A008, 32'hC, 1'b1);
    stallF = 1'b1;
    chk_bus("t3hold", 1'b0, 32'h10);
    tick();
    chk_d("t3e6", 32'h0000_A008, 32'hC, 1'b1);
    stallF = 1'b0; stallD = 1'b0;
    chk_bus("t3rel", 1'b0, 32'h10);
    tick();
    chk_d("t3e7", 32'h0000_A00C, 32'h10, 1'b1);

    // 4: a branch taken while in WAIT goes to DROP.
    // The late response is discarded and fetch restarts at 0x100.
    auto_ack = 1'b0; man_ack = 1'b0;
    chk_bus("t4c8", 1'b1, 32'h10);
    tick();
    chk_d("t4e8", 32'h0, 32'h10, 1'b0);
    pcsrcD = 1'b1; pcbranchD = 32'h100;
    chk_bus("t4c9", 1'b1, 32'h10);
    tick();
    chk_d("t4e9", 32'h0, 32'h10, 1'b0);
    pcsrcD = 1'b0; man_ack = 1'b1;
    chk_bus("t4drop", 1'b1, 32'h10);
    tick();
    chk_d("t4e10", 32'h0, 32'h10, 1'b0);
    man_ack = 1'b0; auto_ack = 1'b1;
    chk_bus("t4c11", 1'b1, 32'h100);
    tick();
    chk_d("t4e11", 32'h0000_A100, 32'h104, 1'b1);

    // 5: when branch and jump fire together, the branch wins.
    // A redirect under stallD is ignored until stallD drops.
    pcsrcD = 1'b1; pcbranchD = 32'h200; jumpD = 1'b1; pcjumpD = 32'h300;
    chk_bus("t5c12", 1'b1, 32'h104);
    tick();
    chk_d("t5e12", 32'h0, 32'h104, 1'b0);
    pcsrcD = 1'b0; jumpD = 1'b0;
    chk_bus("t5c13", 1'b1, 32'h200);
    stallD = 1'b1; stallF = 1'b1; jumpD = 1'b1;
    tick();
    chk_d("t5e13", 32'h0, 32'h104, 1'b0);
    chk_bus("t5stall", 1'b0, 32'h200);
    stallD = 1'b0;
    tick();
    jumpD = 1'b0; stallF = 1'b0;
    chk_bus("t5c15", 1'b1, 32'h300);
    tick();
    chk_d("t5e15", 32'h0000_A300, 32'h304, 1'b1);

    // 6: reset asserted mid-WAIT, with a stray ack while the request is low.
    auto_ack = 1'b0; man_ack = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    chk_bus("t6rst", 1'b0, 32'h0);
    chk_d("t6rst", 32'h0, 32'h0, 1'b0);
    man_ack = 1'b1; stallF = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk_bus("t6stray", 1'b0, 32'h0);
    chk_d("t6stray", 32'h0, 32'h0, 1'b0);
    man_ack = 1'b0; auto_ack = 1'b1; stallF = 1'b0;
    chk_bus("t6restart", 1'b1, 32'h0);
    tick();
    chk_d("t6e", 32'h0000_A000, 32'h4, 1'b1);

    // 7: PC+4 wraps from 0xFFFF_FFFC to 0.
    jumpD = 1'b1; pcjumpD = 32'hFFFF_FFFC;
    tick();
    jumpD = 1'b0;
    chk_bus("t7c", 1'b1, 32'hFFFF_FFFC);
    tick();
    chk_d("t7wrap", 32'hFFFF_FFFC, 32'h0, 1'b1);
    chk_bus("t7next", 1'b1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1);
  end

endmodule
